mem_stream_reader: RTL and testbench
====================================

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width; it SHALL match the attached memory.
REQ-002 SHALL have parameter DEPTH, default 64, memory word count; AW = `CLOG2(DEPTH).
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base  input  AW  first word address, sampled with start.
REQ-007 SHALL have port len  input  AW+1  word count, 0..DEPTH, sampled with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last word's handshake.
REQ-010 SHALL have port mem_address  output  AW  read address to one memory port; write enable held 0 externally.
REQ-011 SHALL have port mem_q  input  WIDTH  memory read data, valid one cycle after the address.
REQ-012 SHALL have port out_data  output  WIDTH  stream data.
REQ-013 SHALL have port out_valid  output  1  stream valid.
REQ-014 SHALL have port out_ready  input  1  stream ready from consumer.
REQ-015 SHALL have port out_last  output  1  high with the final word of a burst.
REQ-016 SHALL have port stall_count  output  32  consumer-stall counter (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE -> RUN (start && len!=0) -> DRAIN (all reads issued) -> DONE (last word accepted) -> IDLE; IDLE -> DONE directly when start && len==0.
REQ-018 SHALL issue at most one read per cycle, addresses base, base+1, ... modulo DEPTH (wrap DEPTH-1 -> 0, also for non-power-of-2 DEPTH).
REQ-019 SHALL capture mem_q exactly one cycle after its address was issued into a 2-entry FIFO.
REQ-020 SHALL issue a read only if (FIFO occupancy + reads in flight) < 2, so no data is ever dropped.
REQ-021 SHALL present FIFO head on out_data/out_valid; a word transfers when out_valid && out_ready.
REQ-022 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-023 SHALL sustain one word per cycle when out_ready is held high (first out_valid 2 cycles after start).
REQ-024 SHALL assert out_last only on word number len of the burst; for len==1 on the single word.
REQ-025 SHALL ignore start while not in IDLE; base/len changes mid-burst SHALL have no effect.
REQ-026 SHALL pulse done for exactly one cycle in DONE, with busy low in that cycle and out_valid low.
REQ-027 SHALL hold mem_address at its last value when no read is issued.

Reset
REQ-028 SHALL, on reset_n low, immediately force IDLE, busy=0, done=0, out_valid=0, out_last=0, out_data=0, mem_address=0, FIFO empty, in-flight cleared, stall_count=0.
REQ-029 SHALL abort any burst on mid-operation reset; no word of it SHALL appear after reset release.

Configuration
REQ-030 SHALL, with macro MEM_STREAM_STALL_COUNT_EN defined, increment stall_count each cycle out_valid && !out_ready, saturating at 2^32-1, cleared on accepted start.
REQ-031 SHALL, without MEM_STREAM_STALL_COUNT_EN, drive stall_count constant 0 with no counter logic.

Verification
REQ-032 SHALL cover: memory holds mem[i]=i, base=5 len=4, ready=1 -> data 5,6,7,8 on consecutive cycles, last on 8, done next cycle.
REQ-033 SHALL cover: DEPTH=64, base=62 len=4 -> data from addresses 62,63,0,1.
REQ-034 SHALL cover: base=0 len=8, out_ready toggled 1/0 each cycle -> all 8 words in order, none duplicated/lost, stall_count=number of stalled-valid cycles (macro on), 0 (macro off).
REQ-035 SHALL cover: start with len=0 -> no out_valid, done pulse one cycle later, busy never high.
REQ-036 SHALL cover: reset_n pulsed low after word 2 of len=10 -> outputs to reset values at once; new start base=0 len=2 -> words 0,1 only.
REQ-037 SHALL cover: start pulsed again during RUN with different base -> ignored, original burst completes unchanged.

Source files
------------

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if
// Ready/valid stream carrying words read out of memory by mem_stream_reader.
//   out_data  : stream word, WIDTH bits
//   out_valid : producer has a word on out_data
//   out_ready : consumer accepts the word this cycle
//   out_last  : word is the final one of its burst
// Modports: master = producer (the reader), slave = consumer.
interface mem_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Reads a burst of len words from a synchronous single-port memory starting
// at base (wrapping modulo DEPTH) and streams them out over a ready/valid
// interface through a 2-entry skid FIFO.
//
// Ports:
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   start          : begin a burst (only honoured in IDLE)
//   base, len      : first address and word count, sampled with start
//   busy, done     : burst in progress / one-cycle completion pulse
//   mem_address    : memory read address (mem_q follows one cycle later)
//   mem_q          : memory read data
//   strm           : stream master (out_data/out_valid/out_ready/out_last)
//   stall_count    : cycles with out_valid && !out_ready
//
// Optional feature: define MEM_STREAM_STALL_COUNT_EN to build the saturating
// stall counter; without it stall_count is tied to zero.
module mem_stream_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [AW-1:0]       base,
    input  logic [AW:0]         len,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       mem_address,
    input  logic [WIDTH-1:0]    mem_q,
    mem_stream_reader_if.master strm,
    output logic [31:0]         stall_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [AW:0] LEN_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] LEN_ONE  = {{AW{1'b0}}, 1'b1};

    // Next sequential address, wrapping DEPTH-1 -> 0 even for non-power-of-2 DEPTH.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return a + {{(AW-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t                  state_r, state_s;
    logic                    busy_r, done_r;
    logic [AW-1:0]           next_addr_r, last_addr_r, issue_addr_s;
    logic [AW:0]             issue_left_r, cap_left_r;
    logic                    inflight_r;
    logic [1:0][WIDTH-1:0]   fifo_data_r;
    logic [1:0]              fifo_last_r;
    logic                    wr_ptr_r, rd_ptr_r;
    logic [1:0]              count_r;
    logic [2:0]              occ_s;
    logic                    accept_s, issue_s, pop_s, out_valid_s, head_last_s;

    assign out_valid_s    = (count_r != 2'd0);
    assign head_last_s    = fifo_last_r[rd_ptr_r];
    assign strm.out_valid = out_valid_s;
    assign strm.out_data  = fifo_data_r[rd_ptr_r];
    assign strm.out_last  = out_valid_s && head_last_s;
    assign busy           = busy_r;
    assign done           = done_r;
    // The address is presented in the issue cycle so that mem_q can be
    // captured on the very next edge; otherwise the last address is held.
    assign mem_address    = issue_s ? issue_addr_s : last_addr_r;

    // Next-state, read-issue and FIFO-pop decisions.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        issue_addr_s = next_addr_r;
        pop_s        = out_valid_s && strm.out_ready;
        // Occupancy seen by the next edge: the word popped now frees its slot,
        // which is what lets a 2-entry FIFO sustain one word per cycle.
        occ_s        = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    issue_addr_s = base;
                    if (len != LEN_ZERO) begin
                        issue_s = 1'b1;
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((issue_left_r != LEN_ZERO) && (occ_s < 3'd2)) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
                if (pop_s && head_last_s) begin
                    state_s = ST_DONE;
                end else if (issue_left_r == LEN_ZERO) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Read-issue bookkeeping: address walk, reads remaining, read in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_addr_r  <= {AW{1'b0}};
            last_addr_r  <= {AW{1'b0}};
            issue_left_r <= LEN_ZERO;
            inflight_r   <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                last_addr_r <= issue_addr_s;
                next_addr_r <= wrap_inc(issue_addr_s);
            end
            if (accept_s) begin
                issue_left_r <= issue_s ? (len - LEN_ONE) : LEN_ZERO;
            end else if (issue_s) begin
                issue_left_r <= issue_left_r - LEN_ONE;
            end else begin
                issue_left_r <= issue_left_r;
            end
        end
    end

    // Two-entry FIFO: capture mem_q one cycle after issue, tag the final word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data_r <= '{default: {WIDTH{1'b0}}};
            fifo_last_r <= 2'b00;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            count_r     <= 2'd0;
            cap_left_r  <= LEN_ZERO;
        end else begin
            if (accept_s) begin
                cap_left_r <= len;
            end else if (inflight_r) begin
                cap_left_r <= cap_left_r - LEN_ONE;
            end else begin
                cap_left_r <= cap_left_r;
            end
            if (inflight_r) begin
                fifo_data_r[wr_ptr_r] <= mem_q;
                fifo_last_r[wr_ptr_r] <= (cap_left_r == LEN_ONE);
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

`ifdef MEM_STREAM_STALL_COUNT_EN
    logic [31:0] stall_r;

    // Saturating count of cycles the consumer holds off a valid word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_r <= 32'd0;
        end else if (accept_s) begin
            stall_r <= 32'd0;
        end else if (out_valid_s && !strm.out_ready && (stall_r != 32'hFFFF_FFFF)) begin
            stall_r <= stall_r + 32'd1;
        end else begin
            stall_r <= stall_r;
        end
    end

    assign stall_count = stall_r;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  base;
    logic [6:0]  len;
    logic        busy, done;
    logic [5:0]  mem_address;
    logic [7:0]  mem_q;
    logic [31:0] stall_count;
    logic [7:0]  mem [64];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] got_data[$];
    bit         got_last[$];
    int         got_k[$];
    int         done_k;
    logic       done_busy, done_valid;

`ifdef MEM_STREAM_STALL_COUNT_EN
    localparam logic [31:0] EXP_TOGGLE_STALLS = 32'd8;
`else
    localparam logic [31:0] EXP_TOGGLE_STALLS = 32'd0;
`endif

    mem_stream_reader_if #(.WIDTH(8)) strm_if ();

    mem_stream_reader #(.WIDTH(8), .DEPTH(64)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .base        (base),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_q       (mem_q),
        .strm        (strm_if),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    // Synchronous-read memory: data one cycle after the address.
    always @(posedge clock) mem_q <= mem[mem_address];

    // Start is high for exactly one rising edge; base/len are then scrambled.
    task automatic start_burst(input logic [5:0] b, input logic [6:0] l);
        @(negedge clock);
        start = 1'b1; base = b; len = l;
        @(negedge clock);
        start = 1'b0; base = 6'h2A; len = 7'd9;
    endtask

    // Drives out_ready per cycle k (k=1 is the cycle after start) and logs transfers.
    task automatic collect(input int ready_mode, input bit inject, input int max_k);
        got_data.delete(); got_last.delete(); got_k.delete();
        done_k = -1; done_busy = 1'bx; done_valid = 1'bx;
        for (int k = 1; (k <= max_k) && (done_k < 0); k++) begin
            strm_if.out_ready = (ready_mode == 0) ? 1'b1 : ((k % 2) == 1);
            if (inject && (k == 2)) begin
                start = 1'b1; base = 6'd40; len = 7'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (strm_if.out_valid && strm_if.out_ready) begin
                got_data.push_back(strm_if.out_data);
                got_last.push_back(strm_if.out_last);
                got_k.push_back(k);
            end
            if (done) begin
                done_k = k; done_busy = busy; done_valid = strm_if.out_valid;
            end
            @(negedge clock);
        end
        start = 1'b0;
        strm_if.out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; base = 6'd0; len = 7'd0; strm_if.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (strm_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", strm_if.out_valid); end
        vectors++; if (strm_if.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last got %b want 0", strm_if.out_last); end
        vectors++; if (strm_if.out_data !== 8'd0) begin miscompares++; $display("FAIL reset_data got %0d want 0", strm_if.out_data); end
        vectors++; if (mem_address !== 6'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", mem_address); end
        vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL reset_stall got %0d want 0", stall_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [7:0] exp_d [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
        start_burst(6'd5, 7'd4);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want 1", busy); end
        vectors++; if (strm_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b want 0", strm_if.out_valid); end
        collect(0, 1'b0, 20);
        vectors++; if (got_data.size() !== 4) begin miscompares++; $display("FAIL basic_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_data.size()) begin
                vectors++; if (got_data[i] !== exp_d[i]) begin miscompares++; $display("FAIL basic_data[%0d] got %0d want %0d", i, got_data[i], exp_d[i]); end
                vectors++; if (got_k[i] !== i + 2) begin miscompares++; $display("FAIL basic_cycle[%0d] got %0d want %0d", i, got_k[i], i + 2); end
                vectors++; if (got_last[i] !== (i == 3)) begin miscompares++; $display("FAIL basic_last[%0d] got %b want %b", i, got_last[i], (i == 3)); end
            end
        end
        vectors++; if (done_k !== 6) begin miscompares++; $display("FAIL basic_done_cycle got %0d want 6", done_k); end
        vectors++; if (done_busy !== 1'b0) begin miscompares++; $display("FAIL basic_done_busy got %b want 0", done_busy); end
        vectors++; if (done_valid !== 1'b0) begin miscompares++; $display("FAIL basic_done_valid got %b want 0", done_valid); end
        #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width got %b want 0", done); end
        vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL basic_stall got %0d want 0", stall_count); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_d [4] = '{8'd62, 8'd63, 8'd0, 8'd1};
        start_burst(6'd62, 7'd4);
        collect(0, 1'b0, 20);
        vectors++; if (got_data.size() !== 4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_data.size()) begin
                vectors++; if (got_data[i] !== exp_d[i]) begin miscompares++; $display("FAIL wrap_data[%0d] got %0d want %0d", i, got_data[i], exp_d[i]); end
            end
        end
        vectors++; if (done_k !== 6) begin miscompares++; $display("FAIL wrap_done_cycle got %0d want 6", done_k); end
    endtask

    task automatic test_stall_toggle;
        start_burst(6'd0, 7'd8);
        collect(1, 1'b0, 60);
        vectors++; if (got_data.size() !== 8) begin miscompares++; $display("FAIL toggle_count got %0d want 8", got_data.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < got_data.size()) begin
                vectors++; if (got_data[i] !== 8'(i)) begin miscompares++; $display("FAIL toggle_data[%0d] got %0d want %0d", i, got_data[i], i); end
                vectors++; if (got_k[i] !== 3 + 2 * i) begin miscompares++; $display("FAIL toggle_cycle[%0d] got %0d want %0d", i, got_k[i], 3 + 2 * i); end
                vectors++; if (got_last[i] !== (i == 7)) begin miscompares++; $display("FAIL toggle_last[%0d] got %b want %b", i, got_last[i], (i == 7)); end
            end
        end
        vectors++; if (done_k !== 18) begin miscompares++; $display("FAIL toggle_done_cycle got %0d want 18", done_k); end
        vectors++; if (stall_count !== EXP_TOGGLE_STALLS) begin miscompares++; $display("FAIL toggle_stall got %0d want %0d", stall_count, EXP_TOGGLE_STALLS); end
    endtask

    task automatic test_zero_len;
        start_burst(6'd3, 7'd0);
        #1;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done got %b want 1", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %b want 0", busy); end
        vectors++; if (strm_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_valid got %b want 0", strm_if.out_valid); end
        vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL zero_stall_cleared got %0d want 0", stall_count); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            vectors++; if ({done, busy, strm_if.out_valid} !== 3'b000) begin miscompares++; $display("FAIL zero_after[%0d] got done/busy/valid %b want 000", i, {done, busy, strm_if.out_valid}); end
        end
    endtask

    task automatic test_reset_mid;
        start_burst(6'd0, 7'd10);
        strm_if.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        vectors++; if (strm_if.out_data !== 8'd2) begin miscompares++; $display("FAIL mid_pre_data got %0d want 2", strm_if.out_data); end
        reset_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", busy); end
        vectors++; if (strm_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", strm_if.out_valid); end
        vectors++; if (strm_if.out_data !== 8'd0) begin miscompares++; $display("FAIL mid_data got %0d want 0", strm_if.out_data); end
        vectors++; if (mem_address !== 6'd0) begin miscompares++; $display("FAIL mid_addr got %0d want 0", mem_address); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            vectors++; if (strm_if.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_valid[%0d] got %b want 0", i, strm_if.out_valid); end
        end
        start_burst(6'd0, 7'd2);
        collect(0, 1'b0, 20);
        vectors++; if (got_data.size() !== 2) begin miscompares++; $display("FAIL mid_new_count got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < got_data.size()) begin
                vectors++; if (got_data[i] !== 8'(i)) begin miscompares++; $display("FAIL mid_new_data[%0d] got %0d want %0d", i, got_data[i], i); end
                vectors++; if (got_last[i] !== (i == 1)) begin miscompares++; $display("FAIL mid_new_last[%0d] got %b want %b", i, got_last[i], (i == 1)); end
            end
        end
        vectors++; if (done_k !== 4) begin miscompares++; $display("FAIL mid_new_done_cycle got %0d want 4", done_k); end
    endtask

    task automatic test_restart_ignored;
        logic [7:0] exp_d [4] = '{8'd10, 8'd11, 8'd12, 8'd13};
        start_burst(6'd10, 7'd4);
        collect(0, 1'b1, 20);
        vectors++; if (got_data.size() !== 4) begin miscompares++; $display("FAIL restart_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_data.size()) begin
                vectors++; if (got_data[i] !== exp_d[i]) begin miscompares++; $display("FAIL restart_data[%0d] got %0d want %0d", i, got_data[i], exp_d[i]); end
            end
        end
        vectors++; if (done_k !== 6) begin miscompares++; $display("FAIL restart_done_cycle got %0d want 6", done_k); end
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if ({busy, strm_if.out_valid} !== 2'b00) begin miscompares++; $display("FAIL restart_after[%0d] got busy/valid %b want 00", i, {busy, strm_if.out_valid}); end
            @(negedge clock);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_stall_toggle();
        test_zero_len();
        test_reset_mid();
        test_restart_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
